// File: rtl/fetch_queue_pkg.sv
// Constants and entry type shared by the PC register and the fetch queue.
// PC_DEFAULT is the architectural reset PC; NOP is the bubble instruction.
package fetch_queue_pkg;

   localparam logic [31:0] PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP        = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// master = fetch/decode side, slave = the queue itself.
interface fetch_queue_if #(
   parameter int unsigned DEPTH = 2
);

   logic                    in_valid;
   logic [31:0]             in_pc;
   logic [31:0]             in_instr;
   logic                    in_ready;
   logic                    out_valid;
   logic [31:0]             out_pc;
   logic [31:0]             out_instr;
   logic                    out_ready;
   logic                    flush;
   logic [$clog2(DEPTH):0]  count;

   modport master (
      output in_valid, in_pc, in_instr, out_ready, flush,
      input  in_ready, out_valid, out_pc, out_instr, count
   );

   modport slave (
      input  in_valid, in_pc, in_instr, out_ready, flush,
      output in_ready, out_valid, out_pc, out_instr, count
   );

endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of {pc, instr} between the PC
// register and decode, with flush and PC_RESET/NOP outputs while empty.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] PC_RESET  = PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.slave  bus
);

   localparam int unsigned     PW   = $clog2(DEPTH);
   localparam int unsigned     CW   = PW + 1;
   localparam logic [CW-1:0]   FULL = CW'(DEPTH);

   fq_entry_t      mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  count_q;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   fq_entry_t      head;

   assign full  = (count_q == FULL);
   assign empty = (count_q == '0);

   // in_ready depends on registered occupancy only, so a full queue
   // refuses a push even when decode pops in the same cycle.
   assign push = bus.in_valid & ~full;
   assign pop  = bus.out_ready & ~empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; empty-state outputs are masked below instead.
   always_ff @(posedge clk) begin
      if (push && !bus.flush) begin
         mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
      end
   end

   assign head          = mem[rd_ptr];
   assign bus.in_ready  = ~full;
   assign bus.out_valid = ~empty;
   assign bus.out_pc    = empty ? PC_RESET  : head.pc;
   assign bus.out_instr = empty ? NOP_INSTR : head.instr;
   assign bus.count     = count_q;

   a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
      (bus.in_valid && bus.in_ready) |-> !full);

   a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
      (bus.out_valid && bus.out_ready) |-> !empty);

   a_count_range: assert property (@(posedge clk) disable iff (!reset)
      count_q <= FULL);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 2;

   logic clk;
   logic reset;

   fetch_queue_if #(.DEPTH(DEPTH)) bus ();

   fetch_queue #(
      .DEPTH     (DEPTH),
      .PC_RESET  (32'h0000_3000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        ordy;
      logic        fl;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      logic [1:0]  e_count;
      logic        e_rdy;
   } vec_t;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   bit [63:0]   mq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, advance past the edge, update the reference queue.
   task automatic apply(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
      bit can_push;
      bit do_pop;
      bus.in_valid  = iv;
      bus.in_pc     = pc;
      bus.in_instr  = ins;
      bus.out_ready = ordy;
      bus.flush     = fl;
      can_push = iv && (mq.size() != DEPTH);
      do_pop   = ordy && (mq.size() != 0);
      @(posedge clk);
      #1;
      if (fl) begin
         mq.delete();
      end else begin
         if (do_pop)   void'(mq.pop_front());
         if (can_push) mq.push_back({pc, ins});
      end
   endtask

   task automatic check_model(input string tag);
      bit [63:0]   h;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      e_pc  = 32'h0000_3000;
      e_ins = 32'h0000_0000;
      if (mq.size() != 0) begin
         h     = mq[0];
         e_pc  = h[63:32];
         e_ins = h[31:0];
      end
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
      chk({tag, ".out_pc"},    bus.out_pc, e_pc);
      chk({tag, ".out_instr"}, bus.out_instr, e_ins);
      chk({tag, ".count"},     32'(bus.count), 32'(mq.size()));
      chk({tag, ".in_ready"},  32'(bus.in_ready), 32'(mq.size() != DEPTH));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".out_pc"},    bus.out_pc, 32'h0000_3000);
      chk({tag, ".out_instr"}, bus.out_instr, 32'h0000_0000);
      chk({tag, ".count"},     32'(bus.count), 32'd0);
      chk({tag, ".in_ready"},  32'(bus.in_ready), 32'd1);
   endtask

   function automatic vec_t mk(logic iv, logic [31:0] pc, logic [31:0] ins, logic ordy,
                               logic fl, logic ev, logic [31:0] ep, logic [31:0] ei,
                               logic [1:0] ec, logic er);
      vec_t v;
      v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy; v.fl = fl;
      v.e_valid = ev; v.e_pc = ep; v.e_ins = ei; v.e_count = ec; v.e_rdy = er;
      return v;
   endfunction

   vec_t tbl[10];

   initial begin
      tbl[0] = mk(1, 32'h3000, 32'h3C01_0001, 0, 0, 1, 32'h3000, 32'h3C01_0001, 2'd1, 1);
      tbl[1] = mk(1, 32'h3004, 32'h3C02_0002, 0, 0, 1, 32'h3000, 32'h3C01_0001, 2'd2, 0);
      tbl[2] = mk(1, 32'h3008, 32'h3C03_0003, 1, 0, 1, 32'h3004, 32'h3C02_0002, 2'd1, 1);
      tbl[3] = mk(0, 32'h0,    32'h0,         0, 0, 1, 32'h3004, 32'h3C02_0002, 2'd1, 1);
      tbl[4] = mk(1, 32'h3008, 32'h3C03_0003, 0, 0, 1, 32'h3004, 32'h3C02_0002, 2'd2, 0);
      tbl[5] = mk(1, 32'h3010, 32'h3C04_0004, 0, 1, 0, 32'h3000, 32'h0,         2'd0, 1);
      tbl[6] = mk(1, 32'h3010, 32'h3C04_0004, 1, 1, 0, 32'h3000, 32'h0,         2'd0, 1);
      tbl[7] = mk(1, 32'h3020, 32'h0000_00AA, 1, 0, 1, 32'h3020, 32'h0000_00AA, 2'd1, 1);
      tbl[8] = mk(1, 32'h3024, 32'h0000_00BB, 1, 0, 1, 32'h3024, 32'h0000_00BB, 2'd1, 1);
      tbl[9] = mk(0, 32'h0,    32'h0,         1, 0, 0, 32'h3000, 32'h0,         2'd0, 1);

      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_pc     = '0;
      bus.in_instr  = '0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      #4 reset = 1'b1;
      apply(0, 32'h0, 32'h0, 0, 0);
      check_reset_values("post_reset");

      for (int i = 0; i < 10; i++) begin
         string t;
         apply(tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].ordy, tbl[i].fl);
         t = $sformatf("vec%0d", i);
         chk({t, ".out_valid"}, 32'(bus.out_valid), 32'(tbl[i].e_valid));
         chk({t, ".out_pc"},    bus.out_pc, tbl[i].e_pc);
         chk({t, ".out_instr"}, bus.out_instr, tbl[i].e_ins);
         chk({t, ".count"},     32'(bus.count), 32'(tbl[i].e_count));
         chk({t, ".in_ready"},  32'(bus.in_ready), 32'(tbl[i].e_rdy));
      end

      // Steady stream: one in, one out per cycle across pointer wrap.
      for (int i = 0; i < 8; i++) begin
         apply(1, 32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1, 0);
         chk($sformatf("stream%0d.pc", i), bus.out_pc, 32'h3000 + 32'(4 * i));
         check_model($sformatf("stream%0d", i));
      end
      apply(0, 32'h0, 32'h0, 1, 0);
      check_model("stream_drain");

      // Asynchronous reset between edges with two entries queued.
      apply(1, 32'h5000, 32'h1111_1111, 0, 0);
      apply(1, 32'h5004, 32'h2222_2222, 0, 0);
      chk("pre_async.count", 32'(bus.count), 32'd2);
      #2 reset = 1'b0;
      #1;
      mq.delete();
      check_reset_values("async_reset");
      #2 reset = 1'b1;
      apply(1, 32'h4180, 32'h3C05_0005, 0, 0);
      chk("after_async.pc", bus.out_pc, 32'h4180);
      check_model("after_async");
      apply(0, 32'h0, 32'h0, 1, 0);
      check_model("after_async_pop");

      // Randomized traffic against the reference queue.
      for (int i = 0; i < 400; i++) begin
         logic        iv;
         logic        ordy;
         logic        fl;
         logic [31:0] pc;
         iv   = 1'($urandom_range(0, 3) != 0);
         ordy = 1'($urandom_range(0, 2) != 0);
         fl   = 1'($urandom_range(0, 15) == 0);
         pc   = $urandom & 32'hFFFF_FFFC;
         apply(iv, pc, $urandom, ordy, fl);
         check_model($sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
